// File: rtl/aes128_ctrl_if.sv
// Requester, response and AES-core signal bundle for aes128_ctrl.
// slave = the controller's view, master = the environment (requesters, sink, core).
interface aes128_ctrl_if;
  logic         req0_valid_i, req1_valid_i;
  logic         req0_ready_o, req1_ready_o;
  logic         req0_enc_or_dec_i, req1_enc_or_dec_i;
  logic [127:0] req0_key_i, req1_key_i;
  logic [127:0] req0_data_i, req1_data_i;

  logic         resp_valid_o, resp_ready_i, resp_id_o, resp_err_o;
  logic [127:0] resp_data_o;

  logic         core_reset_key_o, core_load_data_o, core_enc_or_dec_o;
  logic [127:0] core_cipher_key_o, core_plain_text_o;
  logic         core_key_ready_i, core_cipher_ready_i;
  logic [127:0] core_cipher_text_i;

  modport slave (
    input  req0_valid_i, req1_valid_i, req0_enc_or_dec_i, req1_enc_or_dec_i,
    input  req0_key_i, req1_key_i, req0_data_i, req1_data_i,
    output req0_ready_o, req1_ready_o,
    output resp_valid_o, resp_id_o, resp_err_o, resp_data_o,
    input  resp_ready_i,
    output core_reset_key_o, core_load_data_o, core_enc_or_dec_o,
    output core_cipher_key_o, core_plain_text_o,
    input  core_key_ready_i, core_cipher_ready_i, core_cipher_text_i
  );

  modport master (
    output req0_valid_i, req1_valid_i, req0_enc_or_dec_i, req1_enc_or_dec_i,
    output req0_key_i, req1_key_i, req0_data_i, req1_data_i,
    input  req0_ready_o, req1_ready_o,
    input  resp_valid_o, resp_id_o, resp_err_o, resp_data_o,
    output resp_ready_i,
    input  core_reset_key_o, core_load_data_o, core_enc_or_dec_o,
    input  core_cipher_key_o, core_plain_text_o,
    output core_key_ready_i, core_cipher_ready_i, core_cipher_text_i
  );
endinterface

// File: rtl/aes128_ctrl.sv
// Two-requester job sequencer for an AES-128 core with cycle timeout.
// Optional last-key cache enabled by defining AES128_CTRL_KEY_CACHE_EN.
//
// state     | meaning
// IDLE      | round-robin grant, latch job
// KEY_LOAD  | one-cycle core_reset_key_o pulse
// KEY_WAIT  | wait core_key_ready_i or timeout
// DATA_LOAD | one-cycle core_load_data_o pulse
// DATA_WAIT | wait core_cipher_ready_i (first cycle ignored) or timeout
// RESP      | hold response until resp_ready_i
module aes128_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 63
) (
  input  logic         clk_i,
  input  logic         rst_i,
  aes128_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, KEY_LOAD, KEY_WAIT, DATA_LOAD, DATA_WAIT, RESP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          id_q, id_d;
  logic          mode_q, mode_d;
  logic [127:0]  key_q, key_d;
  logic [127:0]  data_q, data_d;
  logic          resp_id_q, resp_id_d;
  logic          resp_err_q, resp_err_d;
  logic [127:0]  resp_data_q, resp_data_d;

  logic          gnt0, gnt1, hit;
  logic [127:0]  gnt_key;

`ifdef AES128_CTRL_KEY_CACHE_EN
  logic          cache_vld_q, cache_vld_d;
  logic [127:0]  cache_key_q, cache_key_d;
  assign hit = cache_vld_q && (cache_key_q == gnt_key);
`else
  assign hit = 1'b0;
`endif

  // last_q=1 means req1 was granted last, so req0 wins the next contention
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && !rst_i) begin
      if (bus.req0_valid_i && bus.req1_valid_i) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = bus.req0_valid_i;
        gnt1 = bus.req1_valid_i && !bus.req0_valid_i;
      end
    end
  end

  assign gnt_key = gnt1 ? bus.req1_key_i : bus.req0_key_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    id_d        = id_q;
    mode_d      = mode_q;
    key_d       = key_q;
    data_d      = data_q;
    resp_id_d   = resp_id_q;
    resp_err_d  = resp_err_q;
    resp_data_d = resp_data_q;
`ifdef AES128_CTRL_KEY_CACHE_EN
    cache_vld_d = cache_vld_q;
    cache_key_d = cache_key_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          id_d    = gnt1;
          last_d  = gnt1;
          mode_d  = gnt1 ? bus.req1_enc_or_dec_i : bus.req0_enc_or_dec_i;
          key_d   = gnt_key;
          data_d  = gnt1 ? bus.req1_data_i : bus.req0_data_i;
          state_d = hit ? DATA_LOAD : KEY_LOAD;
        end
      end
      KEY_LOAD: begin
        cnt_d   = '0;
        state_d = KEY_WAIT;
`ifdef AES128_CTRL_KEY_CACHE_EN
        cache_vld_d = 1'b0;
`endif
      end
      KEY_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.core_key_ready_i) begin
          state_d = DATA_LOAD;
`ifdef AES128_CTRL_KEY_CACHE_EN
          cache_vld_d = 1'b1;
          cache_key_d = key_q;
`endif
        end else if (cnt_q == TC_LAST) begin
          state_d     = RESP;
          resp_id_d   = id_q;
          resp_err_d  = 1'b1;
          resp_data_d = '0;
        end
      end
      DATA_LOAD: begin
        cnt_d   = '0;
        state_d = DATA_WAIT;
      end
      DATA_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // cnt_q==0 marks the first cycle, where ready may still be the previous job's level
        if (bus.core_cipher_ready_i && cnt_q != '0) begin
          state_d     = RESP;
          resp_id_d   = id_q;
          resp_err_d  = 1'b0;
          resp_data_d = bus.core_cipher_text_i;
        end else if (cnt_q == TC_LAST) begin
          state_d     = RESP;
          resp_id_d   = id_q;
          resp_err_d  = 1'b1;
          resp_data_d = '0;
`ifdef AES128_CTRL_KEY_CACHE_EN
          cache_vld_d = 1'b0;
`endif
        end
      end
      RESP: begin
        if (bus.resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      mode_q      <= 1'b1;
      key_q       <= '0;
      data_q      <= '0;
      resp_id_q   <= 1'b0;
      resp_err_q  <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      id_q        <= id_d;
      mode_q      <= mode_d;
      key_q       <= key_d;
      data_q      <= data_d;
      resp_id_q   <= resp_id_d;
      resp_err_q  <= resp_err_d;
      resp_data_q <= resp_data_d;
    end
  end

`ifdef AES128_CTRL_KEY_CACHE_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cache_vld_q <= 1'b0;
      cache_key_q <= '0;
    end else begin
      cache_vld_q <= cache_vld_d;
      cache_key_q <= cache_key_d;
    end
  end
`endif

  assign bus.req0_ready_o      = gnt0;
  assign bus.req1_ready_o      = gnt1;
  assign bus.resp_valid_o      = (state_q == RESP);
  assign bus.resp_id_o         = resp_id_q;
  assign bus.resp_err_o        = resp_err_q;
  assign bus.resp_data_o       = resp_data_q;
  assign bus.core_reset_key_o  = (state_q == KEY_LOAD);
  assign bus.core_load_data_o  = (state_q == DATA_LOAD);
  assign bus.core_enc_or_dec_o = mode_q;
  assign bus.core_cipher_key_o = key_q;
  assign bus.core_plain_text_o = data_q;

endmodule

// File: doc/aes128_ctrl.md
AES128_CTRL -- requirements
Module: aes128_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 63, the maximum number of cycles to wait for core_key_ready_i or core_cipher_ready_i.
REQ-002 The block SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1, the reset, which is synchronous and active-high.
REQ-004 The block SHALL have ports req0_valid_i / req1_valid_i, input, 1 each, requester job valid.
REQ-005 The block SHALL have ports req0_ready_o / req1_ready_o, output, 1 each, job accepted on valid&ready.
REQ-006 The block SHALL have ports req0_enc_or_dec_i / req1_enc_or_dec_i, input, 1 each: 1 = encrypt, 0 = decrypt.
REQ-007 The block SHALL have ports req0_key_i / req1_key_i, input, 128 each, cipher key.
REQ-008 The block SHALL have ports req0_data_i / req1_data_i, input, 128 each, plaintext or ciphertext.
REQ-009 The block SHALL have ports resp_valid_o (output, 1), resp_ready_i (input, 1), resp_id_o (output, 1, requester index), resp_data_o (output, 128) and resp_err_o (output, 1, timeout).
REQ-010 The block SHALL have core-side outputs core_reset_key_o (1), core_load_data_o (1), core_enc_or_dec_o (1), core_cipher_key_o (128) and core_plain_text_o (128).
REQ-011 The block SHALL have core-side inputs core_key_ready_i (1), core_cipher_ready_i (1) and core_cipher_text_i (128).

Function
REQ-012 The FSM SHALL have states IDLE, KEY_LOAD, KEY_WAIT, DATA_LOAD, DATA_WAIT and RESP.
REQ-013 In IDLE with at least one valid, the block SHALL grant round-robin: the requester not granted last wins on contention, and req0 wins the first contention after reset.
REQ-014 The grant cycle SHALL assert exactly one reqN_ready_o for one cycle and latch id, mode, key and data into job registers; reqN_ready_o SHALL be 0 in every other state.
REQ-015 From IDLE the FSM SHALL go to KEY_LOAD when key re-expansion is required (see Configuration), otherwise to DATA_LOAD.
REQ-016 KEY_LOAD SHALL assert core_reset_key_o for exactly one cycle with core_cipher_key_o equal to the latched key, then go to KEY_WAIT.
REQ-017 KEY_WAIT SHALL go to DATA_LOAD on the first cycle core_key_ready_i=1.
REQ-018 DATA_LOAD SHALL assert core_load_data_o for exactly one cycle with core_plain_text_o and core_enc_or_dec_o driven from the job registers, then go to DATA_WAIT.
REQ-019 core_enc_or_dec_o SHALL hold the job mode unchanged from DATA_LOAD until leaving DATA_WAIT.
REQ-020 In DATA_WAIT, core_cipher_ready_i is ignored in the first cycle (stale level from the previous job); from the second cycle, core_cipher_ready_i=1 SHALL capture core_cipher_text_i into resp_data_o, set resp_err_o=0 and go to RESP.
REQ-021 The timeout counter SHALL clear on entry to KEY_WAIT and to DATA_WAIT and increment each cycle in either state.
REQ-022 When the timeout counter reaches TIMEOUT_CYCLES, the FSM SHALL go to RESP with resp_err_o=1 and resp_data_o=0, and SHALL invalidate the cached key.
REQ-023 RESP SHALL hold resp_valid_o=1 with id, data and err stable until resp_ready_i=1, then return to IDLE; back-pressure of any length is legal.
REQ-024 A requester whose valid drops before being granted SHALL lose nothing; no job is latched.
REQ-025 core_reset_key_o and core_load_data_o SHALL never be asserted in the same cycle.

Reset
REQ-026 On rst_i=1 at a clock edge, from any state including mid-job, the FSM SHALL enter IDLE and the block SHALL drop the in-flight job without a response.
REQ-027 During and after reset, until driven otherwise, the outputs SHALL be: reqN_ready_o=0, resp_valid_o=0, resp_id_o=0, resp_data_o=0, resp_err_o=0, core_reset_key_o=0, core_load_data_o=0, core_enc_or_dec_o=1, core_cipher_key_o=0 and core_plain_text_o=0.
REQ-028 Reset SHALL set the round-robin pointer so that req0 wins the next contention, and SHALL invalidate the cached key.

Configuration
REQ-029 When AES128_CTRL_KEY_CACHE_EN is defined, the block SHALL store the last fully expanded key plus a valid bit, and SHALL skip KEY_LOAD/KEY_WAIT when that key is valid and equal to the granted job's key.
REQ-030 When AES128_CTRL_KEY_CACHE_EN is not defined, every job SHALL pass through KEY_LOAD and KEY_WAIT, and no cache registers SHALL exist.

Verification
REQ-031 req0 encrypt, key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff -> resp_id_o=0, resp_data_o=69c4e0d86a7b0430d8cdb78070b4c55a, resp_err_o=0.
REQ-032 req1 decrypt, same key, data 69c4e0d86a7b0430d8cdb78070b4c55a -> resp_id_o=1, resp_data_o=00112233445566778899aabbccddeeff; with the cache enabled, no core_reset_key_o pulse occurs.
REQ-033 Both requesters valid continuously for four jobs -> grants alternate 0,1,0,1 and responses return in grant order.
REQ-034 Core model never raises core_cipher_ready_i -> resp_valid_o=1 with resp_err_o=1 and resp_data_o=0 exactly TIMEOUT_CYCLES cycles after entering DATA_WAIT; the next job re-expands its key.
REQ-035 rst_i pulsed in KEY_WAIT -> FSM in IDLE next cycle, no response, all outputs at reset values; a subsequent job completes correctly.
REQ-036 resp_ready_i held 0 for 20 cycles in RESP -> resp_valid_o, resp_data_o and resp_id_o stay stable and both reqN_ready_o stay 0.
